// File: rtl/system_widths_pkg.sv
// Shared widths, dispatch modes and saturating arithmetic for the dispatch queue.
package system_widths_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic {
    DISPATCH_RR       = 1'b0,
    DISPATCH_TARGETED = 1'b1
  } dispatch_mode_e;

  // Add a small increment to a 16-bit counter, clamping at all-ones.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {13'd0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Central instruction FIFO: storage array plus read/write pointers and occupancy.
// The caller never pushes when full or pops when empty.
module instr_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage write; the array holds no valid state so it is not reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/instr_dispatch_queue.sv
// Instruction dispatch queue: one central FIFO feeding NUM_CORES core channels,
// either round-robin to any idle ready core or to the core named per entry.
module instr_dispatch_queue
  import system_widths_pkg::*;
#(
  parameter int             NUM_CORES   = 4,
  parameter int             QUEUE_DEPTH = 8,
  parameter dispatch_mode_e MODE        = DISPATCH_RR,
  localparam int SEL_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  localparam int CNT_W   = $clog2(QUEUE_DEPTH) + 1,
  localparam int ENTRY_W = SEL_W + INSTR_W
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INSTR_W-1:0]           in_instr,
  input  logic [SEL_W-1:0]             in_core_sel,
  output logic [NUM_CORES-1:0]         out_valid,
  input  logic [NUM_CORES-1:0]         out_ready,
  output logic [NUM_CORES*INSTR_W-1:0] out_instr,
  input  logic [NUM_CORES-1:0]         core_done,
  input  logic [NUM_CORES-1:0]         core_illegal,
  output logic [NUM_CORES-1:0]         core_busy,
  output logic [CNT_W-1:0]             queue_count,
  output logic [15:0]                  dispatched_count,
  output logic [15:0]                  illegal_count
);

  logic               ready_en;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] head;
  logic [SEL_W-1:0]   head_sel;
  logic [INSTR_W-1:0] head_instr;
  logic [SEL_W-1:0]   rr_ptr;
  logic [NUM_CORES-1:0] avail;
  logic [NUM_CORES-1:0] fire_vec;
  logic               grant_valid;
  logic [SEL_W-1:0]   grant_idx;
  logic               drop;
  logic               fire;
  logic [3:0]         ill_add;
  int                 idx;

  // in_ready stays low through reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) ready_en <= 1'b0;
    else         ready_en <= 1'b1;
  end

  assign in_ready = ready_en && !fifo_full && !flush;
  assign push     = in_valid && in_ready;

  instr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetN (resetN),
    .flush  (flush),
    .push   (push),
    .pop    (pop),
    .wdata  ({in_core_sel, in_instr}),
    .rdata  (head),
    .count  (queue_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign head_sel   = head[ENTRY_W-1 -: SEL_W];
  assign head_instr = head[INSTR_W-1:0];
  assign avail      = out_ready & ~core_busy;
  assign out_instr  = {NUM_CORES{head_instr}};

  // Grant selection; a targeted entry naming a nonexistent core is dropped at the head.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    drop        = 1'b0;
    idx         = 0;
    if (!fifo_empty && !flush) begin
      if (MODE == DISPATCH_RR) begin
        for (int k = 0; k < NUM_CORES; k++) begin
          idx = int'(rr_ptr) + k;
          if (idx >= NUM_CORES) idx = idx - NUM_CORES;
          if (!grant_valid && avail[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = SEL_W'(idx);
          end
        end
      end else begin
        if (int'(head_sel) >= NUM_CORES) begin
          drop = 1'b1;
        end else if (avail[head_sel]) begin
          grant_valid = 1'b1;
          grant_idx   = head_sel;
        end
      end
    end
  end

  // One-hot per-core valid for the granted lane.
  always_comb begin
    out_valid = '0;
    if (grant_valid) out_valid[grant_idx] = 1'b1;
  end

  assign fire_vec = out_valid & out_ready;
  assign fire     = |fire_vec;
  assign pop      = fire || drop;

  // Round-robin pointer moves just past the core that took the last word.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rr_ptr <= '0;
    end else if (flush) begin
      rr_ptr <= '0;
    end else if (MODE == DISPATCH_RR && fire) begin
      if (int'(grant_idx) == NUM_CORES - 1) rr_ptr <= '0;
      else                                  rr_ptr <= grant_idx + 1'b1;
    end
  end

  // Busy tracking: a dispatch in the same cycle as done keeps the core busy.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) core_busy <= '0;
    else         core_busy <= (core_busy & ~core_done) | fire_vec;
  end

  // Illegal increments this cycle: core pulses plus a dropped head entry.
  always_comb begin
    ill_add = 4'(drop);
    for (int i = 0; i < NUM_CORES; i++) ill_add = ill_add + 4'(core_illegal[i]);
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      dispatched_count <= '0;
      illegal_count    <= '0;
    end else begin
      dispatched_count <= sat_add16(dispatched_count, 4'(fire));
      illegal_count    <= sat_add16(illegal_count, ill_add);
    end
  end

endmodule

// File: tb/tb_instr_dispatch_queue.sv
// Bench for instr_dispatch_queue: a round-robin instance (4 cores, depth 8) and a
// targeted instance (3 cores, depth 4) checked every cycle against a queue model.
module tb_instr_dispatch_queue;
  import system_widths_pkg::*;

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] instr;
  } ent_t;

  logic        clk;
  logic        resetN;
  logic        fl   [2];
  logic        iv   [2];
  logic [31:0] ii   [2];
  logic [1:0]  isel [2];
  logic [3:0]  ordy [2];
  logic [3:0]  done [2];
  logic [3:0]  ill  [2];

  wire         rr_ir, tg_ir;
  wire [3:0]   rr_ov, rr_busy, rr_qc;
  wire [2:0]   tg_ov, tg_busy, tg_qc;
  wire [127:0] rr_oi;
  wire [95:0]  tg_oi;
  wire [15:0]  rr_dc, rr_ic, tg_dc, tg_ic;

  int nvec = 0;
  int nmis = 0;

  instr_dispatch_queue #(.NUM_CORES(4), .QUEUE_DEPTH(8), .MODE(DISPATCH_RR)) u_rr (
    .clk(clk), .resetN(resetN), .flush(fl[0]), .in_valid(iv[0]), .in_ready(rr_ir),
    .in_instr(ii[0]), .in_core_sel(isel[0]), .out_valid(rr_ov), .out_ready(ordy[0]),
    .out_instr(rr_oi), .core_done(done[0]), .core_illegal(ill[0]), .core_busy(rr_busy),
    .queue_count(rr_qc), .dispatched_count(rr_dc), .illegal_count(rr_ic));

  instr_dispatch_queue #(.NUM_CORES(3), .QUEUE_DEPTH(4), .MODE(DISPATCH_TARGETED)) u_tg (
    .clk(clk), .resetN(resetN), .flush(fl[1]), .in_valid(iv[1]), .in_ready(tg_ir),
    .in_instr(ii[1]), .in_core_sel(isel[1]), .out_valid(tg_ov), .out_ready(ordy[1][2:0]),
    .out_instr(tg_oi), .core_done(done[1][2:0]), .core_illegal(ill[1][2:0]), .core_busy(tg_busy),
    .queue_count(tg_qc), .dispatched_count(tg_dc), .illegal_count(tg_ic));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  ent_t       mq [2][$];
  logic [3:0] mbusy [2];
  int         mrr [2];
  int         mdisp [2];
  int         mill [2];
  bit         mrdy;

  int         cnt, nc, dep, g, s, pc, idx;
  bit         drp, exp_ir;
  logic [3:0] exp_ov;
  ent_t       hd;
  logic       a_ir;
  logic [3:0] a_ov, a_busy, a_qc;
  logic [127:0] a_oi;
  logic [15:0] a_dc, a_ic;

  always @(negedge clk) begin
    if (!resetN) begin
      for (int k = 0; k < 2; k++) begin
        mq[k].delete();
        mbusy[k] = '0; mrr[k] = 0; mdisp[k] = 0; mill[k] = 0;
      end
      mrdy = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        a_ir = rr_ir; a_ov = rr_ov; a_busy = rr_busy; a_qc = rr_qc;
        a_oi = rr_oi; a_dc = rr_dc; a_ic = rr_ic; nc = 4; dep = 8;
      end else begin
        a_ir = tg_ir; a_ov = {1'b0, tg_ov}; a_busy = {1'b0, tg_busy}; a_qc = {1'b0, tg_qc};
        a_oi = {32'd0, tg_oi}; a_dc = tg_dc; a_ic = tg_ic; nc = 3; dep = 4;
      end
      cnt = mq[k].size();
      exp_ir = mrdy && (cnt < dep) && !fl[k];
      g = -1; drp = 1'b0; hd = '0;
      if (cnt > 0) hd = mq[k][0];
      if (resetN && cnt > 0 && !fl[k]) begin
        if (k == 0) begin
          for (int j = 0; j < nc; j++) begin
            idx = (mrr[k] + j) % nc;
            if (g < 0 && ordy[k][idx] && !mbusy[k][idx]) g = idx;
          end
        end else begin
          s = int'(hd.sel);
          if (s >= nc) drp = 1'b1;
          else if (ordy[k][s] && !mbusy[k][s]) g = s;
        end
      end
      exp_ov = (g >= 0) ? (4'b0001 << g) : 4'b0000;

      check($sformatf("u%0d.in_ready", k), a_ir, exp_ir);
      check($sformatf("u%0d.out_valid", k), a_ov, exp_ov);
      check($sformatf("u%0d.queue_count", k), a_qc, cnt);
      check($sformatf("u%0d.core_busy", k), a_busy, mbusy[k]);
      check($sformatf("u%0d.dispatched_count", k), a_dc, mdisp[k]);
      check($sformatf("u%0d.illegal_count", k), a_ic, mill[k]);
      if (cnt > 0)
        for (int j = 0; j < nc; j++)
          check($sformatf("u%0d.out_instr[%0d]", k, j), a_oi[j*32 +: 32], hd.instr);

      if (resetN) begin
        if (fl[k]) begin
          mq[k].delete();
          mrr[k] = 0;
        end else begin
          if (g >= 0 || drp) void'(mq[k].pop_front());
          if (iv[k] && exp_ir) mq[k].push_back('{sel: isel[k], instr: ii[k]});
        end
        mbusy[k] = mbusy[k] & ~done[k];
        if (g >= 0) begin
          mbusy[k][g] = 1'b1;
          if (mdisp[k] < 65535) mdisp[k]++;
          if (k == 0) mrr[k] = (g + 1) % nc;
        end
        pc = drp ? 1 : 0;
        for (int j = 0; j < nc; j++) pc += ill[k][j] ? 1 : 0;
        mill[k] = (mill[k] + pc > 65535) ? 65535 : mill[k] + pc;
      end
    end
    if (resetN) mrdy = 1'b1;
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    resetN = 1'b0;
    for (int k = 0; k < 2; k++) begin
      fl[k] = 0; iv[k] = 0; ii[k] = '0; isel[k] = '0;
      ordy[k] = '0; done[k] = '0; ill[k] = '0;
    end
    #2;
    check("reset.in_ready", rr_ir, 1'b0);
    check("reset.queue_count", rr_qc, 4'd0);
    check("reset.core_busy", rr_busy, 4'd0);
    check("reset.dispatched_count", rr_dc, 16'd0);
    tick(); tick();
    resetN = 1'b1;
    #1 check("release.in_ready_low", rr_ir, 1'b0);
    tick();
    check("release.in_ready_high", rr_ir, 1'b1);

    // Round robin, all ready: four dispatched, the rest wait for core_done.
    ordy[0] = 4'hF;
    for (int i = 1; i <= 8; i++) begin
      iv[0] = 1'b1; ii[0] = i; tick();
    end
    iv[0] = 1'b0;
    #1 check("rr.count_after_burst", rr_qc, 4'd4);
    check("rr.busy_after_burst", rr_busy, 4'hF);
    for (int i = 0; i < 4; i++) begin
      done[0] = 4'b0001 << i; tick(); done[0] = '0;
      #1 check($sformatf("rr.after_done%0d.valid", i), rr_ov, 4'b0001 << i);
      check($sformatf("rr.after_done%0d.instr", i), rr_oi[i*32 +: 32], 5 + i);
    end
    tick();
    check("rr.dispatched_8", rr_dc, 16'd8);
    check("rr.drained", rr_qc, 4'd0);
    done[0] = 4'hF; tick(); done[0] = '0;

    // Round robin with out_ready=1010: core 1, core 3, then wrap back to core 1.
    ordy[0] = 4'b1010;
    iv[0] = 1'b1; ii[0] = 32'hA1; tick(); iv[0] = 1'b0;
    #1 check("rr1010.first", rr_ov, 4'b0010);
    check("rr1010.first_instr", rr_oi[63:32], 32'hA1);
    tick();
    iv[0] = 1'b1; ii[0] = 32'hA2; tick(); iv[0] = 1'b0;
    #1 check("rr1010.second", rr_ov, 4'b1000);
    tick();
    done[0] = 4'b1010; iv[0] = 1'b1; ii[0] = 32'hA3; tick(); done[0] = '0; iv[0] = 1'b0;
    #1 check("rr1010.wrap", rr_ov, 4'b0010);
    tick();
    done[0] = 4'b1010; tick(); done[0] = '0;

    // Fill with nothing ready; ninth push stalls until a pop frees a slot.
    ordy[0] = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      iv[0] = 1'b1; ii[0] = 32'h10 + i; tick();
    end
    ii[0] = 32'h18;
    #1 check("full.count", rr_qc, 4'd8);
    check("full.in_ready", rr_ir, 1'b0);
    tick(); tick();
    check("full.stalled", rr_qc, 4'd8);
    ordy[0] = 4'b0001;
    #1 check("full.pop_valid", rr_ov, 4'b0001);
    check("full.pop_instr", rr_oi[31:0], 32'h10);
    tick();
    check("full.after_pop", rr_qc, 4'd7);
    check("full.ready_again", rr_ir, 1'b1);
    tick(); iv[0] = 1'b0;
    #1 check("full.ninth_in", rr_qc, 4'd8);

    // Flush with five queued and a simultaneous push.
    ordy[0] = 4'b0000;
    fl[0] = 1'b1; tick(); fl[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      iv[0] = 1'b1; ii[0] = 32'h30 + i; tick();
    end
    iv[0] = 1'b0;
    #1 check("flush.count5", rr_qc, 4'd5);
    fl[0] = 1'b1; iv[0] = 1'b1; ii[0] = 32'hDEAD;
    #1 check("flush.in_ready", rr_ir, 1'b0);
    tick(); fl[0] = 1'b0; iv[0] = 1'b0;
    #1 check("flush.count0", rr_qc, 4'd0);
    check("flush.busy_kept", rr_busy, 4'b0001);
    ordy[0] = 4'b1110;
    #1 check("flush.push_lost", rr_ov, 4'b0000);
    tick(); done[0] = 4'hF; tick(); done[0] = '0; ordy[0] = '0;

    // Illegal counting and saturation.
    #1 check("ill.start", rr_ic, 16'd0);
    ill[0] = 4'b0110; tick(); ill[0] = '0;
    #1 check("ill.plus2", rr_ic, 16'd2);
    acc = 2;
    ill[0] = 4'hF;
    while (acc + 4 <= 65534) begin
      tick(); acc += 4;
    end
    ill[0] = '0;
    #1 check("ill.preload", rr_ic, 16'hFFFE);
    ill[0] = 4'b0110; tick(); ill[0] = '0;
    #1 check("ill.saturate", rr_ic, 16'hFFFF);
    ill[0] = 4'hF; tick(); ill[0] = '0;
    #1 check("ill.hold", rr_ic, 16'hFFFF);

    // Targeted: head for core 2 blocks the entry for core 0 behind it.
    ordy[1] = '0;
    iv[1] = 1'b1; ii[1] = 32'h20; isel[1] = 2'd2; tick();
    ii[1] = 32'h21; isel[1] = 2'd0; tick(); iv[1] = 1'b0;
    ordy[1] = 4'b0001;
    #1 check("hol.blocked", tg_ov, 3'b000);
    tick(); tick();
    check("hol.still_blocked", tg_ov, 3'b000);
    check("hol.count", tg_qc, 3'd2);
    ordy[1] = 4'b0101;
    #1 check("hol.core2", tg_ov, 3'b100);
    check("hol.core2_instr", tg_oi[95:64], 32'h20);
    tick();
    check("hol.core0", tg_ov, 3'b001);
    check("hol.core0_instr", tg_oi[31:0], 32'h21);
    tick();
    check("hol.drained", tg_qc, 3'd0);
    check("hol.dispatched", tg_dc, 16'd2);

    // Targeted entry naming core 3 of 3 is dropped and counted illegal.
    check("drop.ill_before", tg_ic, 16'd0);
    iv[1] = 1'b1; ii[1] = 32'h33; isel[1] = 2'd3; tick(); iv[1] = 1'b0;
    #1 check("drop.queued", tg_qc, 3'd1);
    check("drop.no_valid", tg_ov, 3'b000);
    tick();
    check("drop.gone", tg_qc, 3'd0);
    check("drop.ill_after", tg_ic, 16'd1);

    // Reset mid-dispatch drops queued entries.
    ordy[1] = '0;
    iv[1] = 1'b1; ii[1] = 32'h40; isel[1] = 2'd1; tick();
    ii[1] = 32'h41; tick(); iv[1] = 1'b0;
    #1 check("midreset.count_before", tg_qc, 3'd2);
    resetN = 1'b0;
    #1 check("midreset.count", tg_qc, 3'd0);
    check("midreset.in_ready", tg_ir, 1'b0);
    check("midreset.busy", tg_busy, 3'b000);
    check("midreset.disp", tg_dc, 16'd0);
    check("midreset.rr_ill", rr_ic, 16'd0);
    tick();
    resetN = 1'b1; ordy[0] = 4'hF; ordy[1] = 4'h7;
    #1 check("midreset.no_valid", tg_ov, 3'b000);
    check("midreset.ready_low", tg_ir, 1'b0);
    tick();
    check("midreset.ready_high", tg_ir, 1'b1);
    check("midreset.still_none", tg_ov, 3'b000);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/instr_dispatch_queue.md
INSTR_DISPATCH_QUEUE -- requirements
Module: instr_dispatch_queue

Interface
REQ-001 Parameter NUM_CORES, default 4: number of core instruction channels (1..8).
REQ-002 Parameter QUEUE_DEPTH, default 8: central FIFO entries, power of two, >=2.
REQ-003 Parameter MODE, default DISPATCH_RR: DISPATCH_RR (round-robin to any ready core) or DISPATCH_TARGETED (core named per instruction).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 resetN  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous queue clear.
REQ-007 in_valid  input  1  upstream instruction valid.
REQ-008 in_ready  output  1  queue can accept.
REQ-009 in_instr  input  32  instruction word.
REQ-010 in_core_sel  input  SEL_W=max(1,$clog2(NUM_CORES))  target core, used only in DISPATCH_TARGETED.
REQ-011 out_valid  output  NUM_CORES  per-core instruction valid.
REQ-012 out_ready  input  NUM_CORES  per-core ready; never depends on out_valid.
REQ-013 out_instr  output  NUM_CORES x 32  per-core instruction, all lanes carry the FIFO head word.
REQ-014 core_done  input  NUM_CORES  per-core instruction-done pulse.
REQ-015 core_illegal  input  NUM_CORES  per-core illegal-opcode pulse.
REQ-016 core_busy  output  NUM_CORES  core holds an undone dispatched instruction.
REQ-017 queue_count  output  $clog2(QUEUE_DEPTH)+1  occupied entries.
REQ-018 dispatched_count  output  16  total instructions dispatched, saturating.
REQ-019 illegal_count  output  16  total illegal-opcode pulses, saturating.

Function
REQ-020 Push when in_valid && in_ready; entry stores {in_core_sel, in_instr}.
REQ-021 in_ready = (queue_count < QUEUE_DEPTH) && !flush; no same-cycle bypass when full, no empty-queue pass-through (min latency 1 cycle push-to-out_valid).
REQ-022 Grant (combinational): RR mode -- first index i with out_ready[i] && !core_busy[i], searching from rr_ptr upward with wrap; TARGETED -- stored sel, if out_ready[sel] && !core_busy[sel], else none (head-of-line blocking).
REQ-023 out_valid[i] = queue non-empty && grant==i; at most one bit set per cycle.
REQ-024 Pop on out_valid[i] && out_ready[i]; rr_ptr <= (i+1) mod NUM_CORES on RR pop, unchanged otherwise.
REQ-025 Simultaneous push and pop: queue_count unchanged; both pointers advance, wrapping at QUEUE_DEPTH.
REQ-026 TARGETED sel >= NUM_CORES: entry dropped at head in one cycle, no out_valid, counts as illegal (+1 illegal_count).
REQ-027 core_busy[i] set on pop to i, cleared on core_done[i]; simultaneous done and new dispatch leaves core_busy[i]=1.
REQ-028 core_done[i] while core_busy[i]=0 ignored.
REQ-029 dispatched_count +1 per pop, holds at 16'hFFFF.
REQ-030 illegal_count adds popcount(core_illegal) (+ REQ-026 drop) per cycle, clamped at 16'hFFFF.
REQ-031 flush: queue_count->0, pointers->0, rr_ptr->0, out_valid all 0 that cycle; push that cycle discarded; core_busy and counters unaffected.

Reset
REQ-032 resetN low asynchronously forces: queue empty, pointers 0, rr_ptr 0, core_busy 0, counters 0, out_valid 0, in_ready 0 while asserted.
REQ-033 in_ready rises first rising edge after resetN deasserts; reset mid-dispatch drops all queued entries, no out_valid after deassertion until new push.
REQ-034 FIFO storage array not reset; only valid state is.

Structure
REQ-035 dispatch_mode_e {DISPATCH_RR, DISPATCH_TARGETED} and INSTR_W=32 reside in system_widths_pkg.
REQ-036 Storage and pointers in one sub-module instr_fifo (parametrised WIDTH, DEPTH, with flush); grant, busy tracking and counters in the top.

Verification
REQ-037 RR, 4 cores all ready, push 8 words 0x1..0x8 -> dispatched to cores 0,1,2,3,0... only after core_done; dispatched_count=8.
REQ-038 RR, out_ready=4'b1010 -> first word to core 1, second to core 3, rr_ptr wraps to 0.
REQ-039 Fill QUEUE_DEPTH=8 with all out_ready low -> in_ready=0, queue_count=8; ninth push stalls until one pop.
REQ-040 TARGETED, head sel=2 with core 2 not ready, next sel=0 -> no dispatch (HOL block) until out_ready[2]=1.
REQ-041 Flush with queue_count=5 plus simultaneous push -> queue_count=0 next cycle, pushed word lost, core_busy unchanged.
REQ-042 core_illegal=4'b0110 for 1 cycle -> illegal_count +2; counter preloaded to 0xFFFE via 65534 pulses saturates at 0xFFFF.
